// File: rtl/pc_gen.sv
// Program-counter generator for the rv32core fetch stage: reset vector, prioritised
// redirects, imem req/gnt, halt/resume and PC history. Optional macro: PC_GEN_COMPRESSED_EN.
module pc_gen #(
  parameter int unsigned          WIDTH      = 32,
  parameter logic [WIDTH-1:0]     RESET_VEC  = '0,
  parameter int unsigned          HIST_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_i,
  input  logic                         stall_i,
  input  logic                         trap_i,
  input  logic [WIDTH-1:0]             trap_addr_i,
  input  logic                         jump_i,
  input  logic [WIDTH-1:0]             jump_addr_i,
  input  logic                         branch_i,
  input  logic [WIDTH-1:0]             branch_addr_i,
  input  logic                         halt_i,
  input  logic                         resume_i,
  input  logic                         imem_gnt_i,
`ifdef PC_GEN_COMPRESSED_EN
  input  logic                         is_compressed_i,
`endif
  output logic                         imem_req_o,
  output logic [WIDTH-1:0]             imem_addr_o,
  output logic [WIDTH-1:0]             pc_o,
  output logic [HIST_DEPTH*WIDTH-1:0]  pc_hist_o,
  output logic                         misalign_o,
  output logic                         halted_o
);

`ifdef PC_GEN_COMPRESSED_EN
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(1);
`else
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(3);
`endif

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t                         state;
  logic [HIST_DEPTH-1:0][WIDTH-1:0] hist;
  logic [WIDTH-1:0]               inc_c;
  logic                           redirect_c;
  logic                           advance_c;
  logic                           hist_en_c;

  function automatic logic [WIDTH-1:0] align_addr(input logic [WIDTH-1:0] a);
    return a & ~ALIGN_MASK;
  endfunction

  function automatic logic is_misaligned(input logic [WIDTH-1:0] a);
    return |(a & ALIGN_MASK);
  endfunction

  // Fetch increment: halfword step for compressed instructions when enabled.
  always_comb begin
    inc_c = WIDTH'(4);
`ifdef PC_GEN_COMPRESSED_EN
    if (is_compressed_i) inc_c = WIDTH'(2);
`endif
  end

  // History advances only when the PC takes a new value from a redirect or an advance.
  always_comb begin
    redirect_c = 1'b0;
    advance_c  = 1'b0;
    if (state == RUN) begin
      redirect_c = trap_i | jump_i | branch_i;
      advance_c  = !redirect_c && !halt_i && !stall_i && imem_req_o && imem_gnt_i;
    end else if (state == HALT) begin
      redirect_c = trap_i;
    end
    hist_en_c = redirect_c | advance_c;
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state      <= BOOT;
      pc_o       <= RESET_VEC;
      imem_req_o <= 1'b0;
      halted_o   <= 1'b0;
      misalign_o <= 1'b0;
    end else begin
      misalign_o <= 1'b0;
      unique case (state)
        BOOT: begin
          state      <= RUN;
          imem_req_o <= 1'b1;
        end
        RUN: begin
          if (trap_i) begin
            pc_o <= trap_addr_i;
          end else if (jump_i) begin
            pc_o       <= align_addr(jump_addr_i);
            misalign_o <= is_misaligned(jump_addr_i);
          end else if (branch_i) begin
            pc_o       <= align_addr(branch_addr_i);
            misalign_o <= is_misaligned(branch_addr_i);
          end else if (halt_i) begin
            state      <= HALT;
            imem_req_o <= 1'b0;
            halted_o   <= 1'b1;
          end else if (advance_c) begin
            pc_o <= pc_o + inc_c;
          end
        end
        HALT: begin
          if (trap_i || resume_i) begin
            state      <= RUN;
            imem_req_o <= 1'b1;
            halted_o   <= 1'b0;
          end
          if (trap_i) pc_o <= trap_addr_i;
        end
        default: begin
          state      <= BOOT;
          imem_req_o <= 1'b0;
          halted_o   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < HIST_DEPTH; k++) hist[k] <= RESET_VEC;
    end else if (hist_en_c) begin
      hist[0] <= pc_o;
      for (int unsigned k = 1; k < HIST_DEPTH; k++) hist[k] <= hist[k-1];
    end
  end

  assign imem_addr_o = pc_o;
  assign pc_hist_o   = hist;

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen (RESET_VEC=8000_0000, HIST_DEPTH=2).
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst_i, stall_i, trap_i, jump_i, branch_i, halt_i, resume_i, imem_gnt_i;
  logic [31:0] trap_addr_i, jump_addr_i, branch_addr_i;
  logic        imem_req_o, misalign_o, halted_o;
  logic [31:0] imem_addr_o, pc_o;
  logic [63:0] pc_hist_o;
`ifdef PC_GEN_COMPRESSED_EN
  logic        is_compressed_i;
`endif

  int errors = 0;
  int checks = 0;

  pc_gen #(.WIDTH(32), .RESET_VEC(32'h8000_0000), .HIST_DEPTH(2)) dut (
    .clk(clk), .rst_i(rst_i), .stall_i(stall_i),
    .trap_i(trap_i), .trap_addr_i(trap_addr_i),
    .jump_i(jump_i), .jump_addr_i(jump_addr_i),
    .branch_i(branch_i), .branch_addr_i(branch_addr_i),
    .halt_i(halt_i), .resume_i(resume_i), .imem_gnt_i(imem_gnt_i),
`ifdef PC_GEN_COMPRESSED_EN
    .is_compressed_i(is_compressed_i),
`endif
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .pc_o(pc_o),
    .pc_hist_o(pc_hist_o), .misalign_o(misalign_o), .halted_o(halted_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock; inputs are changed and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_i = 1; stall_i = 0; trap_i = 0; jump_i = 0; branch_i = 0;
    halt_i = 0; resume_i = 0; imem_gnt_i = 0;
    trap_addr_i = '0; jump_addr_i = '0; branch_addr_i = '0;
`ifdef PC_GEN_COMPRESSED_EN
    is_compressed_i = 0;
`endif
    step();
    chk("rst_pc", pc_o, 32'h8000_0000);
    chk("rst_req", 32'(imem_req_o), 32'd0);
    chk("rst_halted", 32'(halted_o), 32'd0);
    chk("rst_misalign", 32'(misalign_o), 32'd0);
    chk("rst_hist0", pc_hist_o[31:0], 32'h8000_0000);
    chk("rst_hist1", pc_hist_o[63:32], 32'h8000_0000);

    rst_i = 0; imem_gnt_i = 1;
    step();
    chk("boot_pc", pc_o, 32'h8000_0000);
    chk("boot_req", 32'(imem_req_o), 32'd1);
    step();
    chk("adv1_pc", pc_o, 32'h8000_0004);
    step();
    chk("adv2_pc", pc_o, 32'h8000_0008);
    chk("adv2_hist0", pc_hist_o[31:0], 32'h8000_0004);
    chk("adv2_hist1", pc_hist_o[63:32], 32'h8000_0000);
    imem_gnt_i = 0;

    jump_i = 1; jump_addr_i = 32'h100;
    step();
    chk("jump_pc", pc_o, 32'h100);
    trap_i = 1; branch_i = 1; trap_addr_i = 32'h200; jump_addr_i = 32'h300; branch_addr_i = 32'h500;
    step();
    chk("prio_pc", pc_o, 32'h200);
    chk("prio_misalign", 32'(misalign_o), 32'd0);
    chk("prio_hist0", pc_hist_o[31:0], 32'h100);
    trap_i = 0; jump_i = 0; branch_addr_i = 32'h402;
    step();
`ifdef PC_GEN_COMPRESSED_EN
    chk("br_mis_pc", pc_o, 32'h402);
    chk("br_mis_flag", 32'(misalign_o), 32'd0);
`else
    chk("br_mis_pc", pc_o, 32'h400);
    chk("br_mis_flag", 32'(misalign_o), 32'd1);
`endif
    branch_i = 0;
    step();
    chk("br_mis_pulse_end", 32'(misalign_o), 32'd0);

    jump_i = 1; jump_addr_i = 32'h40;
    step();
    chk("jump40_pc", pc_o, 32'h40);
    jump_i = 0; stall_i = 1; imem_gnt_i = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_pc", pc_o, 32'h40);
      chk("stall_addr", imem_addr_o, 32'h40);
      chk("stall_req", 32'(imem_req_o), 32'd1);
    end
    chk("stall_hist0", pc_hist_o[31:0], 32'h400);
    stall_i = 0; imem_gnt_i = 1;
    step();
    chk("release_pc", pc_o, 32'h44);
    chk("release_hist0", pc_hist_o[31:0], 32'h40);
    stall_i = 1;
    step();
    chk("stall_gnt_pc", pc_o, 32'h44);
    stall_i = 0; imem_gnt_i = 0;

    jump_i = 1; jump_addr_i = 32'h50;
    step();
    jump_i = 0; halt_i = 1;
    step();
    chk("halt_halted", 32'(halted_o), 32'd1);
    chk("halt_req", 32'(imem_req_o), 32'd0);
    chk("halt_pc", pc_o, 32'h50);
    halt_i = 0; jump_i = 1; jump_addr_i = 32'h300; stall_i = 1;
    step();
    chk("halt_jump_pc", pc_o, 32'h50);
    chk("halt_jump_halted", 32'(halted_o), 32'd1);
    jump_i = 0; stall_i = 0; resume_i = 1;
    step();
    chk("resume_halted", 32'(halted_o), 32'd0);
    chk("resume_req", 32'(imem_req_o), 32'd1);
    chk("resume_pc", pc_o, 32'h50);
    resume_i = 0; halt_i = 1;
    step();
    chk("halt2_halted", 32'(halted_o), 32'd1);
    halt_i = 0; trap_i = 1; trap_addr_i = 32'h10;
    step();
    chk("halt_trap_pc", pc_o, 32'h10);
    chk("halt_trap_halted", 32'(halted_o), 32'd0);
    trap_i = 0; halt_i = 1; resume_i = 1;
    step();
    chk("halt_resume_run", 32'(halted_o), 32'd1);
    halt_i = 0;
    step();
    chk("resume_only", 32'(halted_o), 32'd0);
    resume_i = 0;

    jump_i = 1; jump_addr_i = 32'h203;
    step();
`ifdef PC_GEN_COMPRESSED_EN
    chk("jmp_mis_pc", pc_o, 32'h202);
`else
    chk("jmp_mis_pc", pc_o, 32'h200);
`endif
    chk("jmp_mis_flag", 32'(misalign_o), 32'd1);
    jump_i = 0; trap_i = 1; trap_addr_i = 32'h7;
    step();
    chk("trap_trusted_pc", pc_o, 32'h7);
    chk("trap_trusted_flag", 32'(misalign_o), 32'd0);
    trap_i = 0;

    jump_i = 1; jump_addr_i = 32'hFFFF_FFFC;
    step();
    chk("wrap_pre_pc", pc_o, 32'hFFFF_FFFC);
    jump_i = 0; imem_gnt_i = 1;
    step();
    chk("wrap_pc", pc_o, 32'h0);
    imem_gnt_i = 0; rst_i = 1; jump_i = 1; jump_addr_i = 32'h300;
    step();
    chk("rst_jump_pc", pc_o, 32'h8000_0000);
    chk("rst_jump_req", 32'(imem_req_o), 32'd0);
    chk("rst_jump_hist0", pc_hist_o[31:0], 32'h8000_0000);
    rst_i = 0; jump_i = 0;
    step();
    chk("reboot_req", 32'(imem_req_o), 32'd1);
    chk("reboot_pc", pc_o, 32'h8000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
